// File: rtl/reset_sequencer.sv
// Staged power-on reset sequencer: releases per-domain resets one at a time with an ack
// handshake, and restarts the whole sequence on a debounced button press or watchdog expiry.
module reset_sequencer #(
    parameter int unsigned NUM_STAGES  = 4,
    parameter int unsigned STAGE_DELAY = 16,
    parameter int unsigned DEBOUNCE    = 1000,
    parameter int unsigned WDT_TIMEOUT = 1000000,
    parameter int unsigned ACK_TIMEOUT = 4096
) (
    input  logic                  iTenMHzClk,
    input  logic                  iResetn,
    input  logic                  iButtonn,
    input  logic                  iWdtEn,
    input  logic                  iWdtKick,
    input  logic [NUM_STAGES-1:0] iStageAck,
    output logic [NUM_STAGES-1:0] oStageResetn,
    output logic                  oAllReady,
    output logic [1:0]            oResetCause,
    output logic                  oFault
);

    localparam int unsigned StageW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int unsigned DlyW   = $clog2(STAGE_DELAY + 1);
    localparam int unsigned DbW    = $clog2(DEBOUNCE + 1);
    localparam int unsigned WdtW   = $clog2(WDT_TIMEOUT + 1);
    localparam int unsigned AckW   = $clog2(ACK_TIMEOUT + 1);

    localparam logic [2:0] StHold    = 3'd0;
    localparam logic [2:0] StRelease = 3'd1;
    localparam logic [2:0] StWaitAck = 3'd2;
    localparam logic [2:0] StGap     = 3'd3;
    localparam logic [2:0] StRun     = 3'd4;

    localparam logic [1:0] CausePor    = 2'b00;
    localparam logic [1:0] CauseButton = 2'b01;
    localparam logic [1:0] CauseWdt    = 2'b10;
    localparam logic [1:0] CauseAckTo  = 2'b11;

    logic                  btn_meta_q, btn_sync_q;
    logic [NUM_STAGES-1:0] ack_meta_q, ack_sync_q;
    logic                  btn_level_q, btn_level_d;
    logic [DbW-1:0]        db_cnt_q, db_cnt_d;
    logic                  btn_event_q, btn_event_d;

    logic [2:0]            state_q, state_d;
    logic [StageW-1:0]     stage_q, stage_d;
    logic [DlyW-1:0]       dly_cnt_q, dly_cnt_d;
    logic [AckW-1:0]       ack_cnt_q, ack_cnt_d;
    logic [WdtW-1:0]       wdt_cnt_q, wdt_cnt_d;
    logic [NUM_STAGES-1:0] stage_rstn_q, stage_rstn_d;
    logic                  all_ready_q, all_ready_d;
    logic [1:0]            cause_q, cause_d;
    logic                  fault_q, fault_d;

    logic ack_now, wdt_expire, ack_timeout, wdt_counting;

    // Button debounce: the accepted level follows the synchronized pin only after it has
    // disagreed for DEBOUNCE consecutive cycles. A high-to-low acceptance is one event.
    always_comb begin
        btn_level_d = btn_level_q;
        db_cnt_d    = '0;
        if (btn_sync_q != btn_level_q) begin
            if (db_cnt_q == DbW'(DEBOUNCE - 1)) begin
                btn_level_d = btn_sync_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
        btn_event_d = btn_level_q & ~btn_level_d;
    end

    assign ack_now      = ack_sync_q[stage_q];
    assign wdt_counting = (state_q == StRun) && iWdtEn && !iWdtKick;
    assign wdt_expire   = wdt_counting && (wdt_cnt_q == WdtW'(WDT_TIMEOUT - 1));
    assign ack_timeout  = (state_q == StWaitAck) && !ack_now &&
                          (ack_cnt_q == AckW'(ACK_TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        dly_cnt_d = dly_cnt_q;
        ack_cnt_d = ack_cnt_q;
        cause_d   = cause_q;
        fault_d   = fault_q;
        wdt_cnt_d = (wdt_counting && !wdt_expire) ? wdt_cnt_q + 1'b1 : '0;

        case (state_q)
            StHold: begin
                if (dly_cnt_q == DlyW'(STAGE_DELAY)) begin
                    dly_cnt_d = '0;
                    stage_d   = '0;
                    state_d   = StRelease;
                end else begin
                    dly_cnt_d = dly_cnt_q + 1'b1;
                end
            end
            StRelease: begin
                ack_cnt_d = '0;
                state_d   = StWaitAck;
            end
            StWaitAck: begin
                if (ack_now) begin
                    dly_cnt_d = '0;
                    state_d   = (stage_q == StageW'(NUM_STAGES - 1)) ? StRun : StGap;
                end else if (ack_timeout) begin
                    dly_cnt_d = '0;
                    cause_d   = CauseAckTo;
                    fault_d   = 1'b1;
                    state_d   = StHold;
                end else begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
                end
            end
            StGap: begin
                if (dly_cnt_q == DlyW'(STAGE_DELAY)) begin
                    dly_cnt_d = '0;
                    stage_d   = stage_q + 1'b1;
                    state_d   = StRelease;
                end else begin
                    dly_cnt_d = dly_cnt_q + 1'b1;
                end
            end
            StRun: begin
            end
            default: begin
                dly_cnt_d = '0;
                state_d   = StHold;
            end
        endcase

        // Button beats watchdog beats ack timeout for the reported cause; fault stays set.
        if (state_q != StHold && (btn_event_q || wdt_expire)) begin
            dly_cnt_d = '0;
            cause_d   = btn_event_q ? CauseButton : CauseWdt;
            state_d   = StHold;
        end
    end

    always_comb begin
        stage_rstn_d = stage_rstn_q;
        if (state_d == StHold) begin
            stage_rstn_d = '0;
        end else if (state_q == StRelease) begin
            stage_rstn_d[stage_q] = 1'b1;
        end
        all_ready_d = (state_q == StRun) && (state_d == StRun);
    end

    always_ff @(posedge iTenMHzClk or negedge iResetn) begin
        if (!iResetn) begin
            btn_meta_q   <= 1'b0;
            btn_sync_q   <= 1'b0;
            ack_meta_q   <= '0;
            ack_sync_q   <= '0;
            btn_level_q  <= 1'b0;
            db_cnt_q     <= '0;
            btn_event_q  <= 1'b0;
            state_q      <= StHold;
            stage_q      <= '0;
            dly_cnt_q    <= '0;
            ack_cnt_q    <= '0;
            wdt_cnt_q    <= '0;
            stage_rstn_q <= '0;
            all_ready_q  <= 1'b0;
            cause_q      <= CausePor;
            fault_q      <= 1'b0;
        end else begin
            btn_meta_q   <= iButtonn;
            btn_sync_q   <= btn_meta_q;
            ack_meta_q   <= iStageAck;
            ack_sync_q   <= ack_meta_q;
            btn_level_q  <= btn_level_d;
            db_cnt_q     <= db_cnt_d;
            btn_event_q  <= btn_event_d;
            state_q      <= state_d;
            stage_q      <= stage_d;
            dly_cnt_q    <= dly_cnt_d;
            ack_cnt_q    <= ack_cnt_d;
            wdt_cnt_q    <= wdt_cnt_d;
            stage_rstn_q <= stage_rstn_d;
            all_ready_q  <= all_ready_d;
            cause_q      <= cause_d;
            fault_q      <= fault_d;
        end
    end

    assign oStageResetn = stage_rstn_q;
    assign oAllReady    = all_ready_q;
    assign oResetCause  = cause_q;
    assign oFault       = fault_q;

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Consumes the board-level active-low power-on reset and fans it out as a staged, handshaked sequence of per-domain resets on the 10 MHz clock. Stage resets are released one at a time, each waiting for its domain's ready acknowledge. In run mode, a debounced push-button or a watchdog expiry re-asserts every stage and restarts the sequence. The cause of the last reset is reported.

## Interface
Parameters:
- NUM_STAGES, 4: number of reset domains released in order 0..NUM_STAGES-1.
- STAGE_DELAY, 16: cycles of hold before stage 0 and gap between stages.
- DEBOUNCE, 1000: cycles the synchronized button must be stable before its level is accepted (100 us).
- WDT_TIMEOUT, 1000000: cycles without a kick in RUN before watchdog expiry (100 ms).
- ACK_TIMEOUT, 4096: cycles allowed per stage for its acknowledge.

Ports:
- iTenMHzClk  in  1  system clock; all logic is on its rising edge.
- iResetn  in  1  asynchronous, active-low reset, driven by the power-on reset generator.
- iButtonn  in  1  asynchronous external reset button, active-low.
- iWdtEn  in  1  enables the watchdog in RUN; sampled directly, quasi-static.
- iWdtKick  in  1  single-cycle watchdog kick, synchronous.
- iStageAck  in  NUM_STAGES  per-domain ready, asynchronous, active-high.
- oStageResetn  out  NUM_STAGES  per-domain reset, active-low, registered.
- oAllReady  out  1  high only in RUN.
- oResetCause  out  2  cause of the last sequence: 00 POR, 01 button, 10 watchdog, 11 ack timeout.
- oFault  out  1  sticky flag, set on any ack timeout and cleared only by iResetn.

## Operation
- While iResetn is low, every output is 0: oStageResetn all 0, oAllReady 0, oResetCause 00, oFault 0. The FSM is held in HOLD and all counters are 0.
- iButtonn and each iStageAck bit pass through a 2-FF synchronizer.
- Button debounce:
  - The accepted button level changes only after the synchronized input has differed from it for DEBOUNCE consecutive cycles.
  - A button event is the accepted level going from high to low.
  - Holding the button low gives exactly one event; re-arming requires an accepted release.
- FSM states:
  - HOLD: all oStageResetn 0; count STAGE_DELAY cycles, then set k=0 and go to RELEASE.
  - RELEASE: set oStageResetn[k]=1, clear the ack timer, go to WAIT_ACK.
  - WAIT_ACK:
    - If synced iStageAck[k]=1 and k=NUM_STAGES-1, go to RUN.
    - Otherwise, if synced iStageAck[k]=1, go to GAP.
    - If ACK_TIMEOUT cycles pass without the ack: oResetCause=11, oFault=1, go to HOLD.
  - GAP: count STAGE_DELAY cycles, then k=k+1 and go to RELEASE.
  - RUN: oAllReady=1; the watchdog timer is cleared on entry.
- Restart from any state except HOLD:
  - A button event sets oResetCause=01 and goes to HOLD.
  - A watchdog expiry sets oResetCause=10 and goes to HOLD.
  - Entering HOLD drives all oStageResetn and oAllReady to 0 on the same edge.
- Watchdog:
  - Counts only in RUN with iWdtEn=1.
  - iWdtKick clears it to 0.
  - It expires when it has counted WDT_TIMEOUT cycles since the last kick, RUN entry, or iWdtEn going high.
  - When iWdtEn is low the counter holds at 0.
- Acks of stages already released are not monitored after their handshake; dropping them later has no effect.
- Counter widths are $clog2(max+1) of their limit. There is no wrap: each counter saturates at its terminal count, and the FSM leaves the state on that count.

## Timing
- Stage 0 release: oStageResetn[0] rises STAGE_DELAY+1 cycles after the first edge with iResetn high.
- Ack path latency: ack rising to FSM detection is 2 cycles (synchronizer). The next oStageResetn[k+1] then rises STAGE_DELAY+2 cycles after that detection edge.
- oAllReady rises 1 cycle after the last stage's ack is detected.
- Button response: a low press is accepted DEBOUNCE+2 cycles after the pin falls; oStageResetn drops 1 cycle later.
- Priority within one cycle:
  - Button event beats watchdog expiry; cause 01 is reported.
  - Kick beats expiry; no reset.
  - Button event beats ack timeout; cause 01, but oFault is still set.
- Asynchronous iResetn low at any time, including mid-sequence, forces all reset values immediately. It also clears oFault and the debounce state.

## Test plan
Sim parameters: NUM_STAGES=3, STAGE_DELAY=4, DEBOUNCE=8, WDT_TIMEOUT=64, ACK_TIMEOUT=32.
- POR, acks tied high -> oStageResetn goes 000 -> 001 -> 011 -> 111 with STAGE_DELAY+2 gaps; oAllReady=1; oResetCause=00; oFault=0.
- Stage 1 ack held low -> 32 cycles after stage 1 release, oStageResetn=000, oResetCause=11, oFault=1. After the ack goes high, the sequence completes and oFault stays 1.
- In RUN, button low for 5 cycles (glitch) -> no reset. Button low for 20 cycles -> all stages 0 at DEBOUNCE+3 cycles, oResetCause=01, exactly one restart.
- In RUN with iWdtEn=1:
  - Kick every 60 cycles -> no reset.
  - Stop kicking -> reset 64 cycles after the last kick, oResetCause=10.
  - Kick on the expiry cycle -> no reset.
- iResetn pulsed low during GAP of stage 1 -> outputs 0 immediately, oFault cleared, full sequence restarts from stage 0.
- iWdtEn=0 in RUN for 200 cycles without kicks -> no reset; then iWdtEn=1 -> reset 64 cycles later.
